// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker.
package sysid_checker_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_ID,
    S_WAIT_ID,
    S_REQ_TS,
    S_WAIT_TS,
    S_EVAL,
    S_PAUSE
  } state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam logic [31:0] DEF_EXPECTED_ID = 32'd18;
  localparam logic [31:0] DEF_EXPECTED_TS = 32'd1366147204;

endpackage

// File: rtl/sysid_down_counter.sv
// Loadable, clearable down-counter that stops at zero and flags it.
module sysid_down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock_i,
  input  logic         reset_n_i,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)                      count_d = '0;
    else if (load_i)                  count_d = load_val_i;
    else if (dec_i && count_q != '0)  count_d = count_q - W'(1);
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) count_q <= '0;
    else            count_q <= count_d;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words,
// compares them with build-time values and publishes the results.
//
// state     | meaning
// ----------+--------------------------------------------------
// S_IDLE    | no check pending (after reset: launches first check)
// S_REQ_ID  | read strobe on address 0, waiting for accept
// S_WAIT_ID | waiting for ID readdatavalid
// S_REQ_TS  | read strobe on address 1, waiting for accept
// S_WAIT_TS | waiting for timestamp readdatavalid
// S_EVAL    | compare shadows, update flags, pulse done
// S_PAUSE   | counting down to the next automatic check
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS = DEF_EXPECTED_TS,
  parameter int unsigned POLL_PERIOD = 1000000,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  output logic             sysid_address,
  output logic             sysid_read,
  input  logic             sysid_waitrequest,
  input  logic             sysid_readdatavalid,
  input  logic [31:0]      sysid_readdata,
  output logic             busy,
  output logic             done,
  output logic             id_ok,
  output logic             ts_ok,
  output logic             timeout_err,
  output logic [31:0]      id_value,
  output logic [31:0]      ts_value,
  output logic [CNT_W-1:0] mismatch_count
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  // Loaded with N-1 so the zero flag is seen on the Nth cycle.
  localparam logic [TW-1:0] TMO_LOAD  = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] POLL_LOAD = (POLL_PERIOD == 0) ? '0 : PW'(POLL_PERIOD - 1);

  state_e state_q, state_d;
  logic   first_q;
  logic   abort_q, abort_d;
  logic   id_rd_q, id_rd_d, ts_rd_q, ts_rd_d;
  logic [31:0] id_sh_q, id_sh_d, ts_sh_q, ts_sh_d;

  logic             done_q, id_ok_q, ts_ok_q, tmo_err_q;
  logic [31:0]      id_val_q, ts_val_q;
  logic [CNT_W-1:0] mism_q;

  logic tmo_load, tmo_dec, tmo_zero;
  logic poll_load, poll_clr, poll_dec, poll_zero;
  logic id_ok_n, ts_ok_n;

  always_comb begin
    state_d   = state_q;
    abort_d   = abort_q;
    id_sh_d   = id_sh_q;
    ts_sh_d   = ts_sh_q;
    id_rd_d   = id_rd_q;
    ts_rd_d   = ts_rd_q;
    tmo_dec   = 1'b0;
    poll_load = 1'b0;
    poll_clr  = 1'b0;
    poll_dec  = 1'b0;
    case (state_q)
      S_IDLE: if (first_q || start) state_d = S_REQ_ID;
      S_REQ_ID, S_REQ_TS: begin
        tmo_dec = 1'b1;
        if (!sysid_waitrequest) begin
          state_d = (state_q == S_REQ_ID) ? S_WAIT_ID : S_WAIT_TS;
        end else if (tmo_zero) begin
          state_d = S_EVAL;
          abort_d = 1'b1;
        end
      end
      S_WAIT_ID: begin
        tmo_dec = 1'b1;
        if (sysid_readdatavalid) begin
          id_sh_d = sysid_readdata;
          id_rd_d = 1'b1;
          state_d = S_REQ_TS;
        end else if (tmo_zero) begin
          state_d = S_EVAL;
          abort_d = 1'b1;
        end
      end
      S_WAIT_TS: begin
        tmo_dec = 1'b1;
        if (sysid_readdatavalid) begin
          ts_sh_d = sysid_readdata;
          ts_rd_d = 1'b1;
          state_d = S_EVAL;
        end else if (tmo_zero) begin
          state_d = S_EVAL;
          abort_d = 1'b1;
        end
      end
      S_EVAL: begin
        if (POLL_PERIOD == 0) begin
          state_d = S_IDLE;
        end else begin
          state_d   = S_PAUSE;
          poll_load = 1'b1;
        end
      end
      S_PAUSE: begin
        if (start) begin
          state_d  = S_REQ_ID;
          poll_clr = 1'b1;
        end else if (poll_zero) begin
          state_d = S_REQ_ID;
        end else begin
          poll_dec = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_REQ_ID && state_q != S_REQ_ID) begin
      abort_d = 1'b0;
      id_rd_d = 1'b0;
      ts_rd_d = 1'b0;
    end
  end

  assign tmo_load = (state_d == S_REQ_ID && state_q != S_REQ_ID) ||
                    (state_d == S_REQ_TS && state_q != S_REQ_TS);

  sysid_down_counter #(.W(TW)) u_tmo_cnt (
    .clock_i    (clock),
    .reset_n_i  (reset_n),
    .clear_i    (1'b0),
    .load_i     (tmo_load),
    .load_val_i (TMO_LOAD),
    .dec_i      (tmo_dec),
    .zero_o     (tmo_zero)
  );

  sysid_down_counter #(.W(PW)) u_poll_cnt (
    .clock_i    (clock),
    .reset_n_i  (reset_n),
    .clear_i    (poll_clr),
    .load_i     (poll_load),
    .load_val_i (POLL_LOAD),
    .dec_i      (poll_dec),
    .zero_o     (poll_zero)
  );

  assign id_ok_n = !abort_q && id_rd_q && (id_sh_q == EXPECTED_ID);
  assign ts_ok_n = !abort_q && ts_rd_q && (ts_sh_q == EXPECTED_TS);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      first_q <= 1'b1;
      abort_q <= 1'b0;
      id_rd_q <= 1'b0;
      ts_rd_q <= 1'b0;
      id_sh_q <= '0;
      ts_sh_q <= '0;
    end else begin
      state_q <= state_d;
      first_q <= 1'b0;
      abort_q <= abort_d;
      id_rd_q <= id_rd_d;
      ts_rd_q <= ts_rd_d;
      id_sh_q <= id_sh_d;
      ts_sh_q <= ts_sh_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_q    <= 1'b0;
      id_ok_q   <= 1'b0;
      ts_ok_q   <= 1'b0;
      tmo_err_q <= 1'b0;
      id_val_q  <= '0;
      ts_val_q  <= '0;
      mism_q    <= '0;
    end else begin
      done_q <= (state_q == S_EVAL);
      if (state_q == S_EVAL) begin
        id_ok_q   <= id_ok_n;
        ts_ok_q   <= ts_ok_n;
        tmo_err_q <= abort_q;
        if (id_rd_q) id_val_q <= id_sh_q;
        if (ts_rd_q) ts_val_q <= ts_sh_q;
        if (!(id_ok_n && ts_ok_n) && !(&mism_q)) mism_q <= mism_q + CNT_W'(1);
      end
    end
  end

  assign sysid_read     = (state_q == S_REQ_ID) || (state_q == S_REQ_TS);
  assign sysid_address  = (state_q == S_REQ_TS) ? ADDR_TS : ADDR_ID;
  assign busy           = (state_q != S_IDLE) && (state_q != S_PAUSE);
  assign done           = done_q;
  assign id_ok          = id_ok_q;
  assign ts_ok          = ts_ok_q;
  assign timeout_err    = tmo_err_q;
  assign id_value       = id_val_q;
  assign ts_value       = ts_val_q;
  assign mismatch_count = mism_q;

endmodule
